// File: rtl/reg_wb_arbiter_if.sv
// Writeback requester bundle: ALU (A) and load unit (B) each present a
// destination register and value, and the arbiter answers with a ready.
interface reg_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            a_valid;
  logic            a_ready;
  logic [4:0]      a_rd;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [4:0]      b_rd;
  logic [XLEN-1:0] b_data;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter plus pending-write scoreboard.
// Two requesters share one register file write port through a 1-bit
// round-robin pointer. The scoreboard tracks registers with an issued but
// not yet committed write and flags RAW/WAW hazards at issue.
module reg_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_wb_arbiter_if.slave      wb,
  input  logic                 issue_v,
  input  logic [4:0]           issue_rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic                 hazard,
  output logic                 rf_rd_w,
  output logic [4:0]           rf_rd,
  output logic [XLEN-1:0]      rf_rd_in,
  output logic [31:0]          busy
);

  logic            ptr;
  logic            grant_a;
  logic            grant_b;
  logic            accept;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;
  logic [31:0]     busy_next;

  // Grant the sole valid requester, or the pointed-to one when both are valid; nothing in reset.
  always_comb begin
    grant_a  = rst_n & wb.a_valid & (~wb.b_valid | ~ptr);
    grant_b  = rst_n & wb.b_valid & (~wb.a_valid | ptr);
    accept   = grant_a | grant_b;
    sel_rd   = grant_b ? wb.b_rd   : wb.a_rd;
    sel_data = grant_b ? wb.b_data : wb.a_data;
  end

  assign wb.a_ready = grant_a;
  assign wb.b_ready = grant_b;

  // Hazard looks at the current scoreboard only; a clear landing on this edge is not bypassed.
  always_comb begin
    hazard = issue_v & (((rs1 != 5'd0) & busy[rs1]) |
                        ((rs2 != 5'd0) & busy[rs2]) |
                        ((issue_rd != 5'd0) & busy[issue_rd]));
  end

  // Scoreboard update: clear on commit, set on clean issue, set wins, x0 never tracked.
  always_comb begin
    set_mask = 32'd0;
    clr_mask = 32'd0;
    if (issue_v && !hazard && (issue_rd != 5'd0)) begin
      set_mask[issue_rd] = 1'b1;
    end
    if (rf_rd_w) begin
      clr_mask[rf_rd] = 1'b1;
    end
    busy_next    = (busy & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  // Pointer moves to the requester that lost; holds when nobody is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (grant_a) begin
      ptr <= 1'b1;
    end else if (grant_b) begin
      ptr <= 1'b0;
    end
  end

  // Register file write port: one cycle after acceptance, strobe suppressed for x0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_rd_w  <= 1'b0;
      rf_rd    <= 5'd0;
      rf_rd_in <= '0;
    end else if (accept) begin
      rf_rd_w  <= (sel_rd != 5'd0);
      rf_rd    <= sel_rd;
      rf_rd_in <= sel_data;
    end else begin
      rf_rd_w  <= 1'b0;
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule
